// File: rtl/tic_tac_toe_pkg.sv
// Shared codes and FSM encoding for the N x N tic-tac-toe controller.
// Cell codes and result codes are the same values seen on the board/who ports.
package tic_tac_toe_pkg;

    localparam logic [1:0] CELL_EMPTY  = 2'b00;
    localparam logic [1:0] CELL_PLAYER = 2'b01;
    localparam logic [1:0] CELL_COMP   = 2'b10;

    localparam logic [1:0] WHO_PLAY    = 2'b00;
    localparam logic [1:0] WHO_PLAYER  = 2'b01;
    localparam logic [1:0] WHO_COMP    = 2'b10;
    localparam logic [1:0] WHO_DRAW    = 2'b11;

    typedef enum logic [2:0] {
        P_TURN  = 3'd0,
        P_CHECK = 3'd1,
        C_TURN  = 3'd2,
        C_CHECK = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/ttt_line_detect.sv
// Combinational K-in-a-row finder: flags any horizontal, vertical,
// diagonal or anti-diagonal window of WIN_LEN cells holding code.
module ttt_line_detect #(
    parameter int N       = 3,
    parameter int WIN_LEN = N
) (
    input  logic [2*N*N-1:0] board,
    input  logic [1:0]       code,
    output logic             found
);

    logic [N*N-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < N*N; i++) begin
            hit[i] = (board[2*i +: 2] == code);
        end
    end

    // Every cell is tried as the start of a window in each direction
    always_comb begin
        logic h;
        logic v;
        logic d;
        logic a;
        found = 1'b0;
        h = 1'b0;
        v = 1'b0;
        d = 1'b0;
        a = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                h = (c + WIN_LEN <= N);
                v = (r + WIN_LEN <= N);
                d = h && v;
                a = (c + 1 >= WIN_LEN) && v;
                for (int k = 0; k < WIN_LEN; k++) begin
                    if (c + k < N)
                        h = h & hit[r*N + c + k];
                    if (r + k < N)
                        v = v & hit[(r + k)*N + c];
                    if (r + k < N && c + k < N)
                        d = d & hit[(r + k)*N + c + k];
                    if (r + k < N && c - k >= 0)
                        a = a & hit[(r + k)*N + c - k];
                end
                found = found | h | v | d | a;
            end
        end
    end

endmodule

// File: rtl/tic_tac_toe_nxn.sv
// N x N, K-in-a-row game controller: move arbitration, legality check,
// registered win/draw evaluation one cycle after each accepted move.
module tic_tac_toe_nxn
    import tic_tac_toe_pkg::*;
#(
    parameter  int N       = 3,
    parameter  int WIN_LEN = N,
    localparam int POS_W   = $clog2(N*N),
    localparam int CNT_W   = $clog2(N*N+1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             new_game,
    input  logic             play,
    input  logic             pc,
    input  logic [POS_W-1:0] player_position,
    input  logic [POS_W-1:0] computer_position,
    output logic [2*N*N-1:0] board,
    output logic [1:0]       who,
    output logic             turn,
    output logic             illegal_move,
    output logic [CNT_W-1:0] move_count
);

    localparam int CELLS = N*N;

    state_t             state_q;
    state_t             state_d;
    logic [2*CELLS-1:0] board_q;
    logic [2*CELLS-1:0] board_d;
    logic [2*CELLS-1:0] p_set;
    logic [2*CELLS-1:0] c_set;
    logic [1:0]         who_q;
    logic [1:0]         who_d;
    logic               ill_q;
    logic               ill_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               play_q;
    logic               pc_q;
    logic               play_rise;
    logic               pc_rise;
    logic               p_in;
    logic               c_in;
    logic               p_ok;
    logic               c_ok;
    logic [1:0]         p_cell;
    logic [1:0]         c_cell;
    logic               p_win;
    logic               c_win;

    assign play_rise = play & ~play_q;
    assign pc_rise   = pc & ~pc_q;

    // Decode each requested index once: range check, current content, write mask
    always_comb begin
        p_in   = 1'b0;
        c_in   = 1'b0;
        p_cell = CELL_EMPTY;
        c_cell = CELL_EMPTY;
        p_set  = '0;
        c_set  = '0;
        for (int i = 0; i < CELLS; i++) begin
            if (player_position == POS_W'(i)) begin
                p_in              = 1'b1;
                p_cell            = board_q[2*i +: 2];
                p_set[2*i +: 2]   = CELL_PLAYER;
            end
            if (computer_position == POS_W'(i)) begin
                c_in              = 1'b1;
                c_cell            = board_q[2*i +: 2];
                c_set[2*i +: 2]   = CELL_COMP;
            end
        end
    end

    assign p_ok = p_in && (p_cell == CELL_EMPTY);
    assign c_ok = c_in && (c_cell == CELL_EMPTY);

    ttt_line_detect #(
        .N       (N),
        .WIN_LEN (WIN_LEN)
    ) u_player_line (
        .board (board_q),
        .code  (CELL_PLAYER),
        .found (p_win)
    );

    ttt_line_detect #(
        .N       (N),
        .WIN_LEN (WIN_LEN)
    ) u_comp_line (
        .board (board_q),
        .code  (CELL_COMP),
        .found (c_win)
    );

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        who_d   = who_q;
        cnt_d   = cnt_q;
        ill_d   = 1'b0;
        if (new_game) begin
            state_d = P_TURN;
            board_d = '0;
            who_d   = WHO_PLAY;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                P_TURN: begin
                    if (play_rise) begin
                        if (p_ok) begin
                            board_d = board_q | p_set;
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = P_CHECK;
                        end else begin
                            ill_d = 1'b1;
                        end
                    end
                end
                P_CHECK: begin
                    if (p_win) begin
                        who_d   = WHO_PLAYER;
                        state_d = DONE;
                    end else if (cnt_q == CNT_W'(CELLS)) begin
                        who_d   = WHO_DRAW;
                        state_d = DONE;
                    end else begin
                        state_d = C_TURN;
                    end
                end
                C_TURN: begin
                    if (pc_rise) begin
                        if (c_ok) begin
                            board_d = board_q | c_set;
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = C_CHECK;
                        end else begin
                            ill_d = 1'b1;
                        end
                    end
                end
                C_CHECK: begin
                    if (c_win) begin
                        who_d   = WHO_COMP;
                        state_d = DONE;
                    end else if (cnt_q == CNT_W'(CELLS)) begin
                        who_d   = WHO_DRAW;
                        state_d = DONE;
                    end else begin
                        state_d = P_TURN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = P_TURN;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= P_TURN;
            board_q <= '0;
            who_q   <= WHO_PLAY;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            play_q  <= 1'b0;
            pc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            who_q   <= who_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            play_q  <= new_game ? 1'b0 : play;
            pc_q    <= new_game ? 1'b0 : pc;
        end
    end

    assign board        = board_q;
    assign who          = who_q;
    assign move_count   = cnt_q;
    assign illegal_move = ill_q;
    assign turn         = (state_q == C_TURN) || (state_q == P_CHECK);

endmodule

// File: tb/tb_tic_tac_toe_nxn.sv
// Scoreboard bench for tic_tac_toe_nxn: one 3x3 instance and one 4x4/3-in-a-row.
// Expectations are queued as moves are driven and drained once outputs settle.
module tb_tic_tac_toe_nxn;
    import tic_tac_toe_pkg::*;

    localparam int F_BOARD = 0;
    localparam int F_WHO   = 1;
    localparam int F_TURN  = 2;
    localparam int F_CNT   = 3;
    localparam int F_ILL   = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        ng3 = 1'b0, play3 = 1'b0, pc3 = 1'b0;
    logic [3:0]  pp3 = '0, cp3 = '0;
    logic [17:0] board3;
    logic [1:0]  who3;
    logic        turn3, ill3;
    logic [3:0]  cnt3;

    logic        ng4 = 1'b0, play4 = 1'b0, pc4 = 1'b0;
    logic [3:0]  pp4 = '0, cp4 = '0;
    logic [31:0] board4;
    logic [1:0]  who4;
    logic        turn4, ill4;
    logic [4:0]  cnt4;

    tic_tac_toe_nxn #(.N(3), .WIN_LEN(3)) dut3 (
        .clock             (clock),
        .reset             (reset),
        .new_game          (ng3),
        .play              (play3),
        .pc                (pc3),
        .player_position   (pp3),
        .computer_position (cp3),
        .board             (board3),
        .who               (who3),
        .turn              (turn3),
        .illegal_move      (ill3),
        .move_count        (cnt3)
    );

    tic_tac_toe_nxn #(.N(4), .WIN_LEN(3)) dut4 (
        .clock             (clock),
        .reset             (reset),
        .new_game          (ng4),
        .play              (play4),
        .pc                (pc4),
        .player_position   (pp4),
        .computer_position (cp4),
        .board             (board4),
        .who               (who4),
        .turn              (turn4),
        .illegal_move      (ill4),
        .move_count        (cnt4)
    );

    typedef struct {
        string       tag;
        int          sel;
        int          fld;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ill_tot[2];
    int          ill_base[2];
    logic [31:0] mboard[2];
    int          mcnt[2];

    initial begin
        ill_tot[0] = 0;
        ill_tot[1] = 0;
    end

    always @(negedge clock) begin
        if (ill3) ill_tot[0] = ill_tot[0] + 1;
        if (ill4) ill_tot[1] = ill_tot[1] + 1;
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(int sel, int fld);
        logic [31:0] r;
        r = '0;
        case (fld)
            F_BOARD: r = (sel == 0) ? 32'(board3) : board4;
            F_WHO:   r = (sel == 0) ? 32'(who3) : 32'(who4);
            F_TURN:  r = (sel == 0) ? 32'(turn3) : 32'(turn4);
            F_CNT:   r = (sel == 0) ? 32'(cnt3) : 32'(cnt4);
            default: r = 32'(ill_tot[sel] - ill_base[sel]);
        endcase
        return r;
    endfunction

    task automatic push(string tag, int sel, int fld, logic [31:0] exp);
        exp_t e;
        e.tag = $sformatf("s%0d %s", sel, tag);
        e.sel = sel;
        e.fld = fld;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs(e.sel, e.fld), e.exp);
        end
    endtask

    task automatic set_req(int sel, bit pl, bit cp, int pos);
        if (sel == 0) begin
            play3 = pl;
            pc3   = cp;
            pp3   = 4'(pos);
            cp3   = 4'(pos);
        end else begin
            play4 = pl;
            pc4   = cp;
            pp4   = 4'(pos);
            cp4   = 4'(pos);
        end
    endtask

    task automatic push_all(string tag, int sel, logic [1:0] ewho,
                            bit eturn, bit eill);
        push({tag, " board"}, sel, F_BOARD, mboard[sel]);
        push({tag, " cnt"}, sel, F_CNT, 32'(mcnt[sel]));
        push({tag, " who"}, sel, F_WHO, 32'(ewho));
        push({tag, " turn"}, sel, F_TURN, 32'(eturn));
        push({tag, " ill"}, sel, F_ILL, 32'(eill));
    endtask

    // One request edge, held for `hold` cycles, then ~8 idle cycles
    task automatic mv(int sel, bit is_pc, int pos, bit acc, bit eill,
                      logic [1:0] ewho, bit eturn, int hold = 1);
        string tag;
        tag = $sformatf("%s%0d", is_pc ? "C" : "P", pos);
        ill_base[sel] = ill_tot[sel];
        @(negedge clock);
        set_req(sel, !is_pc, is_pc, pos);
        repeat (hold) @(negedge clock);
        set_req(sel, 1'b0, 1'b0, pos);
        repeat (8) @(negedge clock);
        if (acc) begin
            mboard[sel][2*pos +: 2] = is_pc ? CELL_COMP : CELL_PLAYER;
            mcnt[sel]++;
        end
        push_all(tag, sel, ewho, eturn, eill);
        drain();
    endtask

    task automatic start_new(int sel);
        @(negedge clock);
        if (sel == 0) ng3 = 1'b1;
        else ng4 = 1'b1;
        @(negedge clock);
        ng3 = 1'b0;
        ng4 = 1'b0;
        mboard[sel] = '0;
        mcnt[sel] = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            mboard[s] = '0;
            mcnt[s] = 0;
            ill_base[s] = 0;
        end
        @(negedge clock);
        @(negedge clock);
        for (int s = 0; s < 2; s++) push_all("rst", s, WHO_PLAY, 1'b0, 1'b0);
        drain();
        reset = 1'b0;

        // T1: player wins top row; result appears one cycle after the write
        mv(0, 0, 0, 1, 0, WHO_PLAY, 1);
        mv(0, 1, 4, 1, 0, WHO_PLAY, 0);
        mv(0, 0, 1, 1, 0, WHO_PLAY, 1);
        mv(0, 1, 8, 1, 0, WHO_PLAY, 0);
        ill_base[0] = ill_tot[0];
        @(negedge clock);
        set_req(0, 1, 0, 2);
        @(negedge clock);
        set_req(0, 0, 0, 2);
        mboard[0][5:4] = CELL_PLAYER;
        mcnt[0]++;
        push("P2 wr board", 0, F_BOARD, mboard[0]);
        push("P2 wr who", 0, F_WHO, 32'(WHO_PLAY));
        push("P2 wr turn", 0, F_TURN, 32'd1);
        drain();
        @(negedge clock);
        push("P2 +1 who", 0, F_WHO, 32'(WHO_PLAYER));
        push("P2 +1 turn", 0, F_TURN, 32'd0);
        drain();
        mv(0, 1, 3, 0, 0, WHO_PLAYER, 0);

        // T2: occupied and out-of-range requests are rejected
        start_new(0);
        mv(0, 0, 0, 1, 0, WHO_PLAY, 1);
        mv(0, 1, 0, 0, 1, WHO_PLAY, 1);
        mv(0, 1, 9, 0, 1, WHO_PLAY, 1);
        mv(0, 1, 4, 1, 0, WHO_PLAY, 0);

        // T3: full board with no line is a draw
        start_new(0);
        mv(0, 0, 0, 1, 0, WHO_PLAY, 1);
        mv(0, 1, 1, 1, 0, WHO_PLAY, 0);
        mv(0, 0, 2, 1, 0, WHO_PLAY, 1);
        mv(0, 1, 4, 1, 0, WHO_PLAY, 0);
        mv(0, 0, 3, 1, 0, WHO_PLAY, 1);
        mv(0, 1, 5, 1, 0, WHO_PLAY, 0);
        mv(0, 0, 7, 1, 0, WHO_PLAY, 1);
        mv(0, 1, 6, 1, 0, WHO_PLAY, 0);
        mv(0, 0, 8, 1, 0, WHO_DRAW, 0);

        // T4: 4x4 board, three in a row on each diagonal direction
        mv(1, 0, 5, 1, 0, WHO_PLAY, 1);
        mv(1, 1, 0, 1, 0, WHO_PLAY, 0);
        mv(1, 0, 10, 1, 0, WHO_PLAY, 1);
        mv(1, 1, 1, 1, 0, WHO_PLAY, 0);
        mv(1, 0, 15, 1, 0, WHO_PLAYER, 0);
        start_new(1);
        mv(1, 0, 0, 1, 0, WHO_PLAY, 1);
        mv(1, 1, 3, 1, 0, WHO_PLAY, 0);
        mv(1, 0, 5, 1, 0, WHO_PLAY, 1);
        mv(1, 1, 6, 1, 0, WHO_PLAY, 0);
        mv(1, 0, 15, 1, 0, WHO_PLAY, 1);
        mv(1, 1, 9, 1, 0, WHO_COMP, 0);

        // T5: held level acts once; simultaneous requests favour the mover
        start_new(0);
        mv(0, 0, 0, 1, 0, WHO_PLAY, 1, 5);
        mv(0, 1, 4, 1, 0, WHO_PLAY, 0);
        ill_base[0] = ill_tot[0];
        @(negedge clock);
        play3 = 1'b1;
        pc3   = 1'b1;
        pp3   = 4'd1;
        cp3   = 4'd2;
        @(negedge clock);
        play3 = 1'b0;
        pc3   = 1'b0;
        repeat (4) @(negedge clock);
        mboard[0][3:2] = CELL_PLAYER;
        mcnt[0]++;
        push_all("both", 0, WHO_PLAY, 1'b1, 1'b0);
        drain();

        // T6: async reset between edges, then new_game beats a move
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            mboard[s] = '0;
            mcnt[s] = 0;
            push("arst board", s, F_BOARD, 32'd0);
            push("arst who", s, F_WHO, 32'd0);
            push("arst turn", s, F_TURN, 32'd0);
        end
        drain();
        @(negedge clock);
        reset = 1'b0;
        ill_base[0] = ill_tot[0];
        @(negedge clock);
        ng3 = 1'b1;
        set_req(0, 1, 0, 0);
        @(negedge clock);
        ng3 = 1'b0;
        set_req(0, 0, 0, 0);
        repeat (3) @(negedge clock);
        push_all("ng+play", 0, WHO_PLAY, 1'b0, 1'b0);
        drain();
        mv(0, 0, 0, 1, 0, WHO_PLAY, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
